// File: rtl/bus_rr_fabric.sv
// bus_rr_fabric: N-host to M-device memory-mapped bus with round-robin
// arbitration, address decode, byte enables and a one-cycle response path.
module bus_rr_fabric #(
    parameter int NrHosts      = 2,
    parameter int NrDevices    = 3,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic [NrDevices-1:0]              device_req_o,
    output logic [NrDevices*AddressWidth-1:0] device_addr_o,
    output logic [NrDevices-1:0]              device_we_o,
    output logic [NrDevices*DataWidth/8-1:0]  device_be_o,
    output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
    input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
);

    localparam int BeWidth  = DataWidth / 8;
    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic [AddressWidth-1:0] h_addr  [NrHosts];
    logic [BeWidth-1:0]      h_be    [NrHosts];
    logic [DataWidth-1:0]    h_wdata [NrHosts];
    logic [AddressWidth-1:0] d_base  [NrDevices];
    logic [AddressWidth-1:0] d_mask  [NrDevices];
    logic [DataWidth-1:0]    d_rdata [NrDevices];

    logic [HostIdxW-1:0] last_grant_q, last_grant_d;
    logic [HostIdxW-1:0] win_idx;
    logic                gnt_any;

    logic [AddressWidth-1:0] w_addr;
    logic                    w_we;
    logic [BeWidth-1:0]      w_be;
    logic [DataWidth-1:0]    w_wdata;

    logic               dec_hit;
    logic [DevIdxW-1:0] dec_dev;

    logic                rsp_valid_q, rsp_valid_d;
    logic [HostIdxW-1:0] rsp_host_q, rsp_host_d;
    logic [DevIdxW-1:0]  rsp_dev_q, rsp_dev_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_we_q, rsp_we_d;

    // Split the flattened host and device buses into per-port arrays.
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            h_addr[h]  = host_addr_i[h*AddressWidth +: AddressWidth];
            h_be[h]    = host_be_i[h*BeWidth +: BeWidth];
            h_wdata[h] = host_wdata_i[h*DataWidth +: DataWidth];
        end
        for (int d = 0; d < NrDevices; d++) begin
            d_base[d]  = cfg_device_addr_base_i[d*AddressWidth +: AddressWidth];
            d_mask[d]  = cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth];
            d_rdata[d] = device_rdata_i[d*DataWidth +: DataWidth];
        end
    end

    // Round-robin scan starting just after the last winner; no grant in reset.
    always_comb begin
        gnt_any    = 1'b0;
        win_idx    = last_grant_q;
        host_gnt_o = '0;
        for (int i = 0; i < NrHosts; i++) begin
            int idx;
            idx = (int'(last_grant_q) + 1 + i) % NrHosts;
            if (!gnt_any && rst_i && host_req_i[idx]) begin
                gnt_any = 1'b1;
                win_idx = HostIdxW'(idx);
            end
        end
        if (gnt_any) begin
            host_gnt_o[win_idx] = 1'b1;
        end
        last_grant_d = gnt_any ? win_idx : last_grant_q;
    end

    // Winning host's request fields and lowest-index address decode.
    always_comb begin
        w_addr  = h_addr[win_idx];
        w_we    = host_we_i[win_idx];
        w_be    = h_be[win_idx];
        w_wdata = h_wdata[win_idx];
        dec_hit = 1'b0;
        dec_dev = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!dec_hit && ((w_addr & d_mask[d]) == (d_base[d] & d_mask[d]))) begin
                dec_hit = 1'b1;
                dec_dev = DevIdxW'(d);
            end
        end
    end

    // Forward the granted request to the matched device only.
    always_comb begin
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = '0;
        device_be_o    = '0;
        device_wdata_o = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (gnt_any && dec_hit && (dec_dev == DevIdxW'(d))) begin
                device_req_o[d]                             = 1'b1;
                device_addr_o[d*AddressWidth +: AddressWidth] = w_addr;
                device_we_o[d]                              = w_we;
                device_be_o[d*BeWidth +: BeWidth]           = w_be;
                device_wdata_o[d*DataWidth +: DataWidth]    = w_wdata;
            end
        end
    end

    // Next-state for the response registers, captured on the grant edge.
    always_comb begin
        rsp_valid_d = gnt_any;
        rsp_host_d  = win_idx;
        rsp_dev_d   = dec_dev;
        rsp_err_d   = gnt_any && !dec_hit;
        rsp_we_d    = w_we;
    end

    // Arbitration pointer and response state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant_q <= HostIdxW'(NrHosts - 1);
            rsp_valid_q  <= 1'b0;
            rsp_host_q   <= '0;
            rsp_dev_q    <= '0;
            rsp_err_q    <= 1'b0;
            rsp_we_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_host_q   <= rsp_host_d;
            rsp_dev_q    <= rsp_dev_d;
            rsp_err_q    <= rsp_err_d;
            rsp_we_q     <= rsp_we_d;
        end
    end

    // Return the response to the host granted last cycle; reads carry data.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (rsp_valid_q && (rsp_host_q == HostIdxW'(h))) begin
                host_rvalid_o[h] = 1'b1;
                host_err_o[h]    = rsp_err_q;
                if (!rsp_err_q && !rsp_we_q) begin
                    host_rdata_o[h*DataWidth +: DataWidth] = d_rdata[rsp_dev_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_fabric.sv
// tb_bus_rr_fabric: scoreboard bench for bus_rr_fabric with 2 hosts and
// 3 devices (console, RAM, CLINT) plus a small registered device model.
module tb_bus_rr_fabric;

    localparam int NH = 2;
    localparam int ND = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NH-1:0]     host_req_i, host_gnt_o, host_we_i;
    logic [NH-1:0]     host_rvalid_o, host_err_o;
    logic [NH*AW-1:0]  host_addr_i;
    logic [NH*BW-1:0]  host_be_i;
    logic [NH*DW-1:0]  host_wdata_i, host_rdata_o;
    logic [ND-1:0]     device_req_o, device_we_o;
    logic [ND*AW-1:0]  device_addr_o, cfg_base, cfg_mask;
    logic [ND*BW-1:0]  device_be_o;
    logic [ND*DW-1:0]  device_wdata_o, device_rdata_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            host;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    txn_t          hq[NH][$];
    rsp_t          sb[$];
    logic [AW-1:0] base[ND];
    logic [AW-1:0] mask[ND];
    logic [DW-1:0] dev_rd[ND];
    logic [AW-1:0] addr_tab[5];
    int            checks = 0;
    int            failures = 0;
    int            lg;

    always #5 clk = ~clk;

    bus_rr_fabric #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .host_req_i(host_req_i),
        .host_gnt_o(host_gnt_o),
        .host_addr_i(host_addr_i),
        .host_we_i(host_we_i),
        .host_be_i(host_be_i),
        .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o),
        .host_err_o(host_err_o),
        .device_req_o(device_req_o),
        .device_addr_o(device_addr_o),
        .device_we_o(device_we_o),
        .device_be_o(device_be_o),
        .device_wdata_o(device_wdata_o),
        .device_rdata_i(device_rdata_i),
        .cfg_device_addr_base_i(cfg_base),
        .cfg_device_addr_mask_i(cfg_mask)
    );

    always_comb begin
        for (int d = 0; d < ND; d++) begin
            cfg_base[d*AW +: AW]       = base[d];
            cfg_mask[d*AW +: AW]       = mask[d];
            device_rdata_i[d*DW +: DW] = dev_rd[d];
        end
    end

    function automatic logic [DW-1:0] dev_data(logic [AW-1:0] a, int d);
        if (a == 32'h10 && d == 1) return 32'hDEAD_BEEF;
        return a ^ {4'(d + 1), 28'h5A5_A5A5};
    endfunction

    function automatic int decode(logic [AW-1:0] a);
        for (int d = 0; d < ND; d++)
            if ((a & mask[d]) == (base[d] & mask[d])) return d;
        return -1;
    endfunction

    // Device model: data appears the cycle after a request, junk otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (device_req_o[d])
                dev_rd[d] <= dev_data(device_addr_o[d*AW +: AW], d);
            else
                dev_rd[d] <= 32'hBAD0_0000 | 32'(d);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int h = 0; h < NH; h++) begin
            if (hq[h].size() > 0) begin
                host_req_i[h]              = 1'b1;
                host_addr_i[h*AW +: AW]    = hq[h][0].addr;
                host_we_i[h]               = hq[h][0].we;
                host_be_i[h*BW +: BW]      = hq[h][0].be;
                host_wdata_i[h*DW +: DW]   = hq[h][0].wdata;
            end else begin
                host_req_i[h]              = 1'b0;
                host_addr_i[h*AW +: AW]    = '0;
                host_we_i[h]               = 1'b0;
                host_be_i[h*BW +: BW]      = '0;
                host_wdata_i[h*DW +: DW]   = '0;
            end
        end
    endtask

    task automatic step();
        rsp_t r;
        txn_t t;
        int   win, d;
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            for (int h = 0; h < NH; h++) begin
                chk("rvalid", 64'(host_rvalid_o[h]), 64'(h == r.host));
                chk("rdata", 64'(host_rdata_o[h*DW +: DW]),
                    (h == r.host) ? 64'(r.rdata) : 64'd0);
                chk("err", 64'(host_err_o[h]),
                    (h == r.host) ? 64'(r.err) : 64'd0);
            end
        end else begin
            chk("rvalid_idle", 64'(host_rvalid_o), 64'd0);
        end
        win = -1;
        for (int i = 0; i < NH; i++) begin
            int idx;
            idx = (lg + 1 + i) % NH;
            if (win < 0 && hq[idx].size() > 0) win = idx;
        end
        chk("gnt", 64'(host_gnt_o), (win < 0) ? 64'd0 : (64'd1 << win));
        if (win >= 0) begin
            t = hq[win].pop_front();
            d = decode(t.addr);
            chk("dreq", 64'(device_req_o), (d < 0) ? 64'd0 : (64'd1 << d));
            if (d >= 0) begin
                chk("daddr", 64'(device_addr_o[d*AW +: AW]), 64'(t.addr));
                chk("dwe", 64'(device_we_o[d]), 64'(t.we));
                chk("dbe", 64'(device_be_o[d*BW +: BW]), 64'(t.be));
                chk("dwdata", 64'(device_wdata_o[d*DW +: DW]), 64'(t.wdata));
            end
            r.host  = win;
            r.err   = (d < 0);
            r.rdata = (d < 0 || t.we) ? '0 : dev_data(t.addr, d);
            sb.push_back(r);
            lg = win;
        end else begin
            chk("dreq_idle", 64'(device_req_o), 64'd0);
        end
    endtask

    task automatic push(input int h, input logic [AW-1:0] a, input logic we,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd);
        txn_t t;
        t.addr = a; t.we = we; t.be = be; t.wdata = wd;
        hq[h].push_back(t);
    endtask

    task automatic set_map();
        base[0] = 32'h0002_0000; mask[0] = 32'hFFFF_0000;
        base[1] = 32'h0000_0000; mask[1] = 32'hFFE0_0000;
        base[2] = 32'h0003_0000; mask[2] = 32'hFFFF_0000;
    endtask

    initial begin
        int n;
        set_map();
        addr_tab[0] = 32'h0000_0100;
        addr_tab[1] = 32'h0002_0010;
        addr_tab[2] = 32'h0003_0004;
        addr_tab[3] = 32'h0100_0000;
        addr_tab[4] = 32'h001F_FFFC;
        rst_n = 1'b0;
        host_req_i = '0; host_addr_i = '0; host_we_i = '0;
        host_be_i = '0; host_wdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        host_req_i = 2'b11;
        host_addr_i = {32'h10, 32'h10};
        #2;
        chk("rst_gnt", 64'(host_gnt_o), 64'd0);
        chk("rst_dreq", 64'(device_req_o), 64'd0);
        chk("rst_rvalid", 64'(host_rvalid_o), 64'd0);
        chk("rst_rdata", 64'(host_rdata_o), 64'd0);
        chk("rst_err", 64'(host_err_o), 64'd0);
        host_req_i = '0; host_addr_i = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lg = NH - 1;

        push(0, 32'h10, 1'b0, 4'hF, '0);
        step(); step();

        push(0, 32'h20, 1'b0, 4'hF, '0);
        push(0, 32'h24, 1'b0, 4'hF, '0);
        push(1, 32'h30, 1'b0, 4'hF, '0);
        push(1, 32'h34, 1'b0, 4'hF, '0);
        repeat (5) step();

        push(1, 32'h0100_0000, 1'b1, 4'hF, 32'h1111_2222);
        step(); step();

        base[0] = 32'h0; mask[0] = 32'hFFFF_0000;
        push(0, 32'h100, 1'b0, 4'hF, '0);
        step(); step();
        set_map();

        push(0, 32'h40, 1'b1, 4'h3, 32'h1234_5678);
        push(0, 32'h40, 1'b0, 4'hF, '0);
        push(1, 32'h0002_0004, 1'b1, 4'h0, 32'hCAFE_0000);
        repeat (4) step();

        for (int c = 0; c < 40; c++) begin
            for (int h = 0; h < NH; h++) begin
                if (hq[h].size() < 2 && $urandom_range(0, 1) == 1)
                    push(h, addr_tab[$urandom_range(0, 4)],
                         1'($urandom_range(0, 1)), 4'($urandom),
                         $urandom);
            end
            step();
        end
        n = 0;
        while ((hq[0].size() > 0 || hq[1].size() > 0) && n < 20) begin
            step();
            n++;
        end
        chk("drain", 64'(hq[0].size() + hq[1].size()), 64'd0);
        step();

        push(1, 32'h0003_0008, 1'b0, 4'hF, '0);
        step();
        @(posedge clk);
        #1;
        host_req_i = 2'b11;
        host_addr_i = {32'h10, 32'h10};
        #1;
        chk("pre_rst_rvalid", 64'(host_rvalid_o), 64'b10);
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(host_rvalid_o), 64'd0);
        chk("midrst_rdata", 64'(host_rdata_o), 64'd0);
        chk("midrst_gnt", 64'(host_gnt_o), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        host_req_i = '0; host_addr_i = '0;
        rst_n = 1'b1;
        lg = NH - 1;
        push(0, 32'h50, 1'b0, 4'hF, '0);
        push(1, 32'h54, 1'b0, 4'hF, '0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
